// File: rtl/if_id_stage_pkg.sv
// if_id_stage_pkg: shared CPU encodings and the supervisor-preserving PC+4 helper
package if_id_stage_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] ILLOP     = 32'h8000_0004;
  localparam logic [31:0] XADR      = 32'h8000_0008;
  typedef enum logic [2:0] {
    PCSRC_SEQ   = 3'b000,
    PCSRC_BR    = 3'b001,
    PCSRC_JMP   = 3'b010,
    PCSRC_JR    = 3'b011,
    PCSRC_ILLOP = 3'b100,
    PCSRC_XADR  = 3'b101
  } pcsrc_t;
  // bit31 is the supervisor flag and never takes the carry out of bit30
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    logic [31:0] s;
    s = pc + 32'd4;
    return {pc[31], s[30:0]};
  endfunction
endpackage

// File: rtl/if_id_stage_hazard_detect.sv
// hazard_detect: load-use compare between a load in EX and the sources of the instruction in ID
module hazard_detect
  import if_id_stage_pkg::*;
(
  input  logic       mem_read,
  input  logic [4:0] rt,
  input  logic       valid,
  input  logic [4:0] src_a,
  input  logic [4:0] src_b,
  output logic       hz
);
  // $zero never carries a dependency, and bubbles have no sources
  assign hz = mem_read & (rt != 5'd0) & valid & ((rt == src_a) | (rt == src_b));
endmodule

// File: rtl/if_id_stage.sv
// if_id_stage: IF/ID pipeline register with load-use stall, flush bubbles and irq bubble injection
module if_id_stage #(
  parameter logic [31:0] NOP_INSTR = if_id_stage_pkg::NOP_INSTR,
  parameter logic [31:0] RESET_PC  = 32'h0800_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [31:0] instr_in,
  input  logic        flush,
  input  logic        id_ex_mem_read,
  input  logic [4:0]  id_ex_rt,
  input  logic        irq,
  output logic        pc_write,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        if_id_irq,
  output logic        irq_ack
);
  import if_id_stage_pkg::*;
  logic hz;
  logic irq_pend;
  logic ins;
  hazard_detect u_hazard (
    .mem_read (id_ex_mem_read),
    .rt       (id_ex_rt),
    .valid    (if_id_valid),
    .src_a    (if_id_instr[25:21]),
    .src_b    (if_id_instr[20:16]),
    .hz       (hz)
  );
  // a flush overrides the stall so the PC can take the redirect target
  assign pc_write = ~hz | flush;
  // irq bubble only on an edge that is neither flushing nor stalling, and only in user mode
  assign ins = irq_pend & ~pc[31] & ~flush & ~hz;
  // IF/ID register, pending-irq latch and ack pulse with flush > stall > irq > normal priority
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_id_instr    <= NOP_INSTR;
      if_id_pc       <= RESET_PC;
      if_id_pc_plus4 <= RESET_PC + 32'd4;
      if_id_valid    <= 1'b0;
      if_id_irq      <= 1'b0;
      irq_ack        <= 1'b0;
      irq_pend       <= 1'b0;
    end else begin
      irq_pend <= ~ins & (irq_pend | (irq & ~pc[31]));
      irq_ack  <= ins;
      if (flush) begin
        if_id_instr <= NOP_INSTR;
        if_id_valid <= 1'b0;
        if_id_irq   <= 1'b0;
      end else if (!hz) begin
        if_id_instr    <= ins ? NOP_INSTR : instr_in;
        if_id_pc       <= pc;
        if_id_pc_plus4 <= pc_plus4(pc);
        if_id_valid    <= ~ins;
        if_id_irq      <= ins;
      end
    end
  end
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: directed checks of fetch, stall, flush, irq injection, async reset and PC wrap
module tb_if_id_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = 32'h0;
  logic [31:0] instr_in = 32'h0;
  logic        flush = 1'b0;
  logic        id_ex_mem_read = 1'b0;
  logic [4:0]  id_ex_rt = 5'd0;
  logic        irq = 1'b0;
  logic        pc_write;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        if_id_irq;
  logic        irq_ack;
  int total = 0;
  int bad = 0;

  if_id_stage dut (
    .clk            (clk),
    .reset          (reset),
    .pc             (pc),
    .instr_in       (instr_in),
    .flush          (flush),
    .id_ex_mem_read (id_ex_mem_read),
    .id_ex_rt       (id_ex_rt),
    .irq            (irq),
    .pc_write       (pc_write),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_valid    (if_id_valid),
    .if_id_irq      (if_id_irq),
    .irq_ack        (irq_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_instr"}, if_id_instr, 32'h0);
    chk({tag, "_pc"}, if_id_pc, 32'h0800_0000);
    chk({tag, "_pc4"}, if_id_pc_plus4, 32'h0800_0004);
    chk({tag, "_valid"}, {31'b0, if_id_valid}, 32'd0);
    chk({tag, "_irq"}, {31'b0, if_id_irq}, 32'd0);
    chk({tag, "_ack"}, {31'b0, irq_ack}, 32'd0);
    chk({tag, "_pcw"}, {31'b0, pc_write}, 32'd1);
  endtask

  initial begin
    #1 reset = 1'b0;
    #1 chk_reset_vals("rst");
    #10 reset = 1'b1;
    // normal fetch
    pc = 32'h0000_0010; instr_in = 32'h2008_0005;
    step();
    chk("t1_instr", if_id_instr, 32'h2008_0005);
    chk("t1_pc", if_id_pc, 32'h0000_0010);
    chk("t1_pc4", if_id_pc_plus4, 32'h0000_0014);
    chk("t1_valid", {31'b0, if_id_valid}, 32'd1);
    chk("t1_pcw", {31'b0, pc_write}, 32'd1);
    // load-use on rs: add $t2,$t0,$t1
    pc = 32'h0000_0014; instr_in = 32'h0109_5020;
    step();
    chk("t2_instr", if_id_instr, 32'h0109_5020);
    id_ex_mem_read = 1'b1; id_ex_rt = 5'd8;
    pc = 32'h0000_0018; instr_in = 32'hDEAD_BEEF;
    #1 chk("t2_pcw_rs", {31'b0, pc_write}, 32'd0);
    step();
    chk("t2_hold_instr", if_id_instr, 32'h0109_5020);
    chk("t2_hold_pc", if_id_pc, 32'h0000_0014);
    chk("t2_hold_pc4", if_id_pc_plus4, 32'h0000_0018);
    chk("t2_hold_valid", {31'b0, if_id_valid}, 32'd1);
    id_ex_rt = 5'd9;
    #1 chk("t2_pcw_rt", {31'b0, pc_write}, 32'd0);
    id_ex_rt = 5'd0;
    #1 chk("t2_pcw_zero", {31'b0, pc_write}, 32'd1);
    step();
    chk("t2_go_instr", if_id_instr, 32'hDEAD_BEEF);
    chk("t2_go_pc", if_id_pc, 32'h0000_0018);
    id_ex_mem_read = 1'b0;
    // flush during stall
    pc = 32'h0000_0020; instr_in = 32'h0109_5020;
    step();
    id_ex_mem_read = 1'b1; id_ex_rt = 5'd8; flush = 1'b1;
    #1 chk("t3_pcw", {31'b0, pc_write}, 32'd1);
    step();
    chk("t3_instr", if_id_instr, 32'h0);
    chk("t3_valid", {31'b0, if_id_valid}, 32'd0);
    chk("t3_irq", {31'b0, if_id_irq}, 32'd0);
    flush = 1'b0;
    #1 chk("t3_pcw_bubble", {31'b0, pc_write}, 32'd1);
    id_ex_mem_read = 1'b0; id_ex_rt = 5'd0;
    // interrupt in user mode
    pc = 32'h0000_0040; instr_in = 32'h1111_1111; irq = 1'b1;
    step();
    chk("t4_first_valid", {31'b0, if_id_valid}, 32'd1);
    chk("t4_first_ack", {31'b0, irq_ack}, 32'd0);
    irq = 1'b0; pc = 32'h0000_0044; instr_in = 32'h2222_2222;
    step();
    chk("t4_irq", {31'b0, if_id_irq}, 32'd1);
    chk("t4_pc", if_id_pc, 32'h0000_0044);
    chk("t4_pc4", if_id_pc_plus4, 32'h0000_0048);
    chk("t4_instr", if_id_instr, 32'h0);
    chk("t4_valid", {31'b0, if_id_valid}, 32'd0);
    chk("t4_ack", {31'b0, irq_ack}, 32'd1);
    chk("t4_pcw", {31'b0, pc_write}, 32'd1);
    pc = 32'h8000_0004; instr_in = 32'h3333_3333;
    step();
    chk("t4_ack_drop", {31'b0, irq_ack}, 32'd0);
    chk("t4_irq_drop", {31'b0, if_id_irq}, 32'd0);
    chk("t4_kpc4", if_id_pc_plus4, 32'h8000_0008);
    // kernel mode masks irq
    pc = 32'h8000_0040; instr_in = 32'h4444_4444; irq = 1'b1;
    step();
    irq = 1'b0; pc = 32'h0000_0050; instr_in = 32'h5050_5050;
    step();
    chk("t4_mask_irq", {31'b0, if_id_irq}, 32'd0);
    chk("t4_mask_instr", if_id_instr, 32'h5050_5050);
    chk("t4_mask_ack", {31'b0, irq_ack}, 32'd0);
    // pending irq deferred by flush
    pc = 32'h0000_0060; instr_in = 32'h5555_5555; irq = 1'b1;
    step();
    irq = 1'b0; flush = 1'b1;
    step();
    chk("t5_flush_irq", {31'b0, if_id_irq}, 32'd0);
    chk("t5_flush_valid", {31'b0, if_id_valid}, 32'd0);
    chk("t5_flush_ack", {31'b0, irq_ack}, 32'd0);
    flush = 1'b0; pc = 32'h0000_0064;
    step();
    chk("t5_irq", {31'b0, if_id_irq}, 32'd1);
    chk("t5_pc", if_id_pc, 32'h0000_0064);
    chk("t5_ack", {31'b0, irq_ack}, 32'd1);
    // async reset during a stall with an irq pending
    pc = 32'h0000_0070; instr_in = 32'h0109_5020; irq = 1'b1;
    step();
    irq = 1'b0; id_ex_mem_read = 1'b1; id_ex_rt = 5'd8;
    #1 chk("t6_stall", {31'b0, pc_write}, 32'd0);
    step();
    #2 reset = 1'b0;
    #1 chk_reset_vals("t6");
    #1 reset = 1'b1;
    id_ex_mem_read = 1'b0; id_ex_rt = 5'd0;
    pc = 32'h0000_0100; instr_in = 32'h6666_6666;
    step();
    chk("t6_no_irq", {31'b0, if_id_irq}, 32'd0);
    chk("t6_instr", if_id_instr, 32'h6666_6666);
    chk("t6_valid", {31'b0, if_id_valid}, 32'd1);
    // PC+4 wrap keeps bit31
    pc = 32'h7FFF_FFFC;
    step();
    chk("t7_user_wrap", if_id_pc_plus4, 32'h0000_0000);
    pc = 32'hFFFF_FFFC;
    step();
    chk("t7_kern_wrap", if_id_pc_plus4, 32'h8000_0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
